// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store bus bridge.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Encodings outside B/H/W/BU/HU fall back to a word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering, byte-enable generation, misalignment detection and
// load extraction/extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic [1:0]  size_o,
  output logic        uns_o,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_uns_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] rdata_o
);

  size_e       st_size;
  size_e       ld_size;
  logic [31:0] lane;

  always_comb begin
    st_size      = f3_size(funct3_i);
    size_o       = st_size;
    uns_o        = f3_unsigned(funct3_i);
    be_o         = '0;
    wdata_o      = '0;
    misaligned_o = 1'b0;
    case (st_size)
      SZ_B: begin
        be_o    = BE_B << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        be_o         = addr_lo_i[1] ? (BE_H << 2) : BE_H;
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        be_o         = BE_W;
        wdata_o      = wdata_i;
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

  always_comb begin
    ld_size = size_e'(ld_size_i);
    lane    = ld_word_i >> {ld_off_i, 3'b000};
    rdata_o = ld_word_i;
    case (ld_size)
      SZ_B:    rdata_o = ld_uns_i ? {24'b0, lane[7:0]}
                                  : {{24{lane[7]}}, lane[7:0]};
      SZ_H:    rdata_o = ld_uns_i ? {16'b0, lane[15:0]}
                                  : {{16{lane[15]}}, lane[15:0]};
      default: rdata_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Converts the core's data-memory strobes into one valid/ready bus
// transaction, stalling the core until the access completes or times out.
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             bus_err_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [1:0]       off_q;

  logic             strobe;
  logic             start;
  logic             expired;
  logic [3:0]       be_w;
  logic [31:0]      wdata_w;
  logic             mis_w;
  logic [1:0]       size_w;
  logic             uns_w;
  logic [31:0]      rdata_fmt;

  lsu_align u_align (
    .funct3_i    (funct3),
    .addr_lo_i   (addr[1:0]),
    .wdata_i     (wdata),
    .be_o        (be_w),
    .wdata_o     (wdata_w),
    .misaligned_o(mis_w),
    .size_o      (size_w),
    .uns_o       (uns_w),
    .ld_size_i   (size_q),
    .ld_uns_i    (uns_q),
    .ld_off_i    (off_q),
    .ld_word_i   (bus_rdata),
    .rdata_o     (rdata_fmt)
  );

  assign strobe  = mem_read | mem_write;
  assign start   = (state_q == IDLE) & strobe & ~mis_w;
  // Saturating counter: a late accept in REQ leaves no budget for WAIT_R.
  assign expired = cnt_q >= CNT_W'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = REQ;
      REQ: begin
        if (bus_ready)    state_d = we_q ? DONE : WAIT_R;
        else if (expired) state_d = DONE;
      end
      WAIT_R: if (bus_rvalid || expired) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    misaligned = 1'b0;
    bus_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        misaligned = strobe & mis_w;
        stall      = strobe & ~mis_w;
      end
      REQ: begin
        bus_valid = 1'b1;
        stall     = 1'b1;
      end
      WAIT_R:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      off_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            we_q      <= mem_write;
            addr_q    <= {addr[31:2], 2'b00};
            be_q      <= be_w;
            wdata_q   <= wdata_w;
            size_q    <= size_w;
            uns_q     <= uns_w;
            off_q     <= addr[1:0];
          end
        end
        REQ: begin
          if (cnt_q != CNT_W'(TIMEOUT)) cnt_q <= cnt_q + CNT_W'(1);
          if (!bus_ready && expired) begin
            bus_err_q <= 1'b1;
            rdata_q   <= '0;
          end
        end
        WAIT_R: begin
          if (cnt_q != CNT_W'(TIMEOUT)) cnt_q <= cnt_q + CNT_W'(1);
          if (bus_rvalid) begin
            rdata_q <= rdata_fmt;
          end else if (expired) begin
            bus_err_q <= 1'b1;
            rdata_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign bus_err   = bus_err_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: vector table, bus responder with
// a request scoreboard, and hand-written timeout/reset sequences.
module tb_lsu_bus_bridge;
  import lsu_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        stall, misaligned, bus_err, bus_valid, bus_we;
  logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;

  lsu_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rsp;
    int          rl, rv;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] bwd, rdata;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  req_t        exp_q[$];
  int          n_tests = 0, n_fail = 0;
  int          ready_lat = 0, rv_lat = 0;
  logic [31:0] rsp_data = '0;
  logic [31:0] last_rdata = '0;
  int          vcnt = 0, rcnt = 0;
  bit          rd_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rsp, input int rl, input int rv,
                              input logic mis, input logic [3:0] be,
                              input logic [31:0] bwd, input logic [31:0] rdv);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.rsp = rsp;
    v.rl = rl; v.rv = rv; v.mis = mis; v.be = be; v.bwd = bwd; v.rdata = rdv;
    return v;
  endfunction

  // Bus slave: accepts after ready_lat REQ cycles (never if negative), then
  // pulses rvalid rv_lat cycles after the cycle following the accept.
  always @(negedge clk) begin
    req_t e;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    if (rd_pend) begin
      if (rcnt == rv_lat) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rsp_data;
        rd_pend    = 1'b0;
      end
      rcnt++;
    end
    if (bus_valid) begin
      if (ready_lat >= 0 && vcnt >= ready_lat) begin
        bus_ready = 1'b1;
        vcnt      = 0;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: actual addr=%h required none", bus_addr);
        end else begin
          e = exp_q.pop_front();
          chk("bus_we", bus_we, e.we);
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_be", bus_be, e.be);
          chk("bus_wdata", bus_wdata, e.wd);
        end
        if (!bus_we) begin
          rd_pend = 1'b1;
          rcnt    = 0;
        end
      end else begin
        vcnt++;
      end
    end else begin
      vcnt = 0;
    end
  end

  task automatic run_access(input vec_t v, input int exp_stall, input logic exp_err);
    int   n;
    int   nv;
    req_t r;
    @(negedge clk);
    ready_lat = v.rl;
    rv_lat    = v.rv;
    rsp_data  = v.rsp;
    if (!v.mis && v.rl >= 0) begin
      r.we = v.wr; r.addr = {v.addr[31:2], 2'b00}; r.be = v.be; r.wd = v.bwd;
      exp_q.push_back(r);
    end
    mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    #1;
    chk("misaligned", misaligned, v.mis);
    chk("stall_issue", stall, !v.mis);
    if (v.mis) begin
      @(negedge clk);
      #1;
      chk("mis_no_valid", bus_valid, 1'b0);
      chk("mis_hold", misaligned, 1'b1);
    end else begin
      n  = 1;
      nv = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        #1;
        if (bus_valid) nv++;
        if (!stall) break;
        n++;
      end
      chk("stall_cycles", n, exp_stall);
      chk("done_valid", bus_valid, 1'b0);
      chk("done_err", bus_err, exp_err);
      if (exp_err) last_rdata = '0;
      else if (v.rd && !v.wr) last_rdata = v.rdata;
      chk("rdata", rdata, last_rdata);
      if (exp_err) chk("timeout_valid_cycles", nv, (v.rl < 0) ? TO : 1);
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  vec_t vecs[$];
  vec_t hv;

  initial begin
    //        rd wr f3     addr          wdata         rsp           rl rv mis be       bwd           rdata
    vecs.push_back(mk(0, 1, F3_W,  32'h104, 32'hDEADBEEF, 32'h0,        0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(0, 1, F3_B,  32'h203, 32'h000000A5, 32'h0,        0, 0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(1, 0, F3_B,  32'h301, 32'h0,        32'h12348000, 0, 0, 0, 4'b0010, 32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(1, 0, F3_BU, 32'h301, 32'h0,        32'h12348000, 0, 0, 0, 4'b0010, 32'h0,        32'h00000080));
    vecs.push_back(mk(1, 0, F3_H,  32'h302, 32'h0,        32'h12348000, 0, 0, 0, 4'b1100, 32'h0,        32'h00001234));
    vecs.push_back(mk(1, 0, F3_W,  32'h402, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, F3_H,  32'h401, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(0, 1, F3_H,  32'h106, 32'h0000BEEF, 32'h0,        0, 0, 0, 4'b1100, 32'hBEEFBEEF, 32'h0));
    vecs.push_back(mk(1, 0, F3_HU, 32'h300, 32'h0,        32'h1234F00D, 0, 0, 0, 4'b0011, 32'h0,        32'h0000F00D));
    vecs.push_back(mk(1, 0, F3_H,  32'h300, 32'h0,        32'h1234F00D, 0, 0, 0, 4'b0011, 32'h0,        32'hFFFFF00D));
    vecs.push_back(mk(1, 0, F3_W,  32'h500, 32'h0,        32'hCAFEF00D, 2, 2, 0, 4'b1111, 32'h0,        32'hCAFEF00D));
    vecs.push_back(mk(0, 1, 3'b011, 32'h600, 32'h0BADC0DE, 32'h0,       3, 0, 0, 4'b1111, 32'h0BADC0DE, 32'h0));
    vecs.push_back(mk(1, 0, 3'b111, 32'h604, 32'h0,       32'h89ABCDEF, 0, 1, 0, 4'b1111, 32'h0,        32'h89ABCDEF));
    vecs.push_back(mk(1, 0, 3'b110, 32'h601, 32'h0,       32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, F3_B,  32'h702, 32'h1234567E, 32'h0,        0, 0, 0, 4'b0100, 32'h7E7E7E7E, 32'h0));
    vecs.push_back(mk(1, 0, F3_B,  32'h302, 32'h0,        32'h007F0000, 0, 0, 0, 4'b0100, 32'h0,        32'h0000007F));

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_bus_we", bus_we, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", bus_be, 4'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_misaligned", misaligned, 1'b0);
    rst = 1'b0;

    // Stall cycles: issue cycle in IDLE, REQ for rl+1 cycles, WAIT_R for rv+1.
    foreach (vecs[i]) begin
      hv = vecs[i];
      run_access(hv, hv.wr ? (2 + hv.rl) : (3 + hv.rl + hv.rv), 1'b0);
    end

    // Never accepted: TIMEOUT cycles in REQ after the issue cycle.
    hv = mk(1, 0, F3_W, 32'h800, 32'h0, 32'h0, -1, 0, 0, 4'b1111, 32'h0, 32'h0);
    run_access(hv, TO + 1, 1'b1);
    hv = mk(0, 1, F3_W, 32'h804, 32'h13572468, 32'h0, 0, 0, 0, 4'b1111, 32'h13572468, 32'h0);
    run_access(hv, 2, 1'b0);

    // Accepted at once but the response arrives too late; it then lands in IDLE.
    hv = mk(1, 0, F3_W, 32'h900, 32'h0, 32'h77777777, 0, 20, 0, 4'b1111, 32'h0, 32'h0);
    run_access(hv, TO + 1, 1'b1);
    repeat (12) @(negedge clk);
    #1;
    chk("late_rsp_rdata", rdata, 32'h0);
    chk("late_rsp_stall", stall, 1'b0);
    chk("late_rsp_err_held", bus_err, 1'b1);

    hv = mk(1, 0, F3_W, 32'h904, 32'h0, 32'h2468ACE0, 0, 0, 0, 4'b1111, 32'h0, 32'h2468ACE0);
    run_access(hv, 3, 1'b0);

    // Reset while in WAIT_R, then the response pulses in IDLE.
    @(negedge clk);
    ready_lat = 0; rv_lat = 6; rsp_data = 32'h55AA55AA;
    hv = mk(1, 0, F3_W, 32'hA00, 32'h0, 32'h0, 0, 0, 0, 4'b1111, 32'h0, 32'h0);
    exp_q.push_back('{we: 1'b0, addr: 32'hA00, be: 4'b1111, wd: 32'h0});
    mem_read = 1'b1; funct3 = F3_W; addr = 32'hA00; wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("wait_r_stall", stall, 1'b1);
    chk("wait_r_valid", bus_valid, 1'b0);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_valid", bus_valid, 1'b0);
    chk("mid_rst_addr", bus_addr, 32'h0);
    repeat (10) @(negedge clk);
    #1;
    chk("ignored_rsp_rdata", rdata, 32'h0);
    chk("ignored_rsp_stall", stall, 1'b0);
    last_rdata = '0;
    hv = mk(0, 1, F3_W, 32'hB00, 32'hFEEDFACE, 32'h0, 0, 0, 0, 4'b1111, 32'hFEEDFACE, 32'h0);
    run_access(hv, 2, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
